// File: rtl/gpr_alu.sv
// 32x32 register file with a combinational ALU on read port 1 and operand alu_b.
// Optional GPR_ALU_OVF_FLAG_EN: a write edge with signed overflow sets bit 0 of register 30.
module gpr_alu #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gpr_wr,
    input  logic [4:0]        rr1,
    input  logic [4:0]        rr2,
    input  logic [4:0]        wr,
    input  logic [DATA_W-1:0] wd,
    input  logic              slt_wr,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [1:0]        alu_sel,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] alu_out,
    output logic              zero,
    output logic              overflow,
    output logic              less_than
);

    logic [DATA_W-1:0]        regs [0:31];
    logic signed [DATA_W-1:0] op_a;
    logic signed [DATA_W-1:0] op_b;
    logic signed [DATA_W-1:0] sum;
    logic signed [DATA_W-1:0] diff;
    logic [DATA_W-1:0]        wr_val;

    function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b,
                                     input logic signed [DATA_W-1:0] s);
        return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b,
                                     input logic signed [DATA_W-1:0] d);
        return (a[DATA_W-1] != b[DATA_W-1]) && (d[DATA_W-1] != a[DATA_W-1]);
    endfunction

    // Reads are gated by rst so the ports show 0 for the whole reset interval.
    assign read_data1 = (rst || rr1 == 5'd0) ? '0 : regs[rr1];
    assign read_data2 = (rst || rr2 == 5'd0) ? '0 : regs[rr2];

    assign op_a      = read_data1;
    assign op_b      = alu_b;
    assign sum       = op_a + op_b;
    assign diff      = op_a - op_b;
    assign less_than = (op_a < op_b);
    assign zero      = (alu_out == '0);

    always_comb begin
        alu_out  = sum;
        overflow = 1'b0;
        case (alu_sel)
            2'b00: begin
                alu_out  = sum;
                overflow = add_ovf(op_a, op_b, sum);
            end
            2'b01: begin
                alu_out  = diff;
                overflow = sub_ovf(op_a, op_b, diff);
            end
            2'b10:   alu_out = op_a | op_b;
            default: alu_out = op_a & op_b;
        endcase
    end

    assign wr_val = slt_wr ? {{(DATA_W-1){1'b0}}, less_than} : wd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (gpr_wr && wr != 5'd0) begin
                regs[wr] <= wr_val;
            end
`ifdef GPR_ALU_OVF_FLAG_EN
            // Later assignment wins: merges a same-edge write to r30 with the sticky flag.
            if (gpr_wr && overflow) begin
                regs[30] <= ((wr == 5'd30) ? wr_val : regs[30]) | {{(DATA_W-1){1'b0}}, 1'b1};
            end
`endif
        end
    end

endmodule

// File: tb/tb_gpr_alu.sv
// Directed self-checking bench for gpr_alu; expectations track GPR_ALU_OVF_FLAG_EN.
module tb_gpr_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gpr_wr = 1'b0;
    logic [4:0]  rr1 = '0;
    logic [4:0]  rr2 = '0;
    logic [4:0]  wr = '0;
    logic [31:0] wd = '0;
    logic        slt_wr = 1'b0;
    logic [31:0] alu_b = '0;
    logic [1:0]  alu_sel = '0;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] alu_out;
    logic        zero;
    logic        overflow;
    logic        less_than;

    int total = 0;
    int bad = 0;

    gpr_alu dut (
        .clk        (clk),
        .rst        (rst),
        .gpr_wr     (gpr_wr),
        .rr1        (rr1),
        .rr2        (rr2),
        .wr         (wr),
        .wd         (wd),
        .slt_wr     (slt_wr),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .alu_out    (alu_out),
        .zero       (zero),
        .overflow   (overflow),
        .less_than  (less_than)
    );

    always #5 clk = ~clk;

`ifdef GPR_ALU_OVF_FLAG_EN
    localparam bit FLAG_EN = 1'b1;
`else
    localparam bit FLAG_EN = 1'b0;
`endif

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        gpr_wr = 1'b1; wr = a; wd = d; slt_wr = 1'b0; alu_sel = 2'b10;
        @(posedge clk); #1;
        gpr_wr = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
        rr1 = a; #1;
        d = read_data1;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        write_reg(5'd7, 32'hDEADBEEF);
        write_reg(5'd31, 32'h12345678);
        #2 rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rr2 = i[4:0];
            read_reg(i[4:0], v);
            total++;
            if (v !== 32'h0) begin
                bad++; $display("FAIL reset_rd1[%0d] got=%h exp=00000000", i, v);
            end
            total++;
            if (read_data2 !== 32'h0) begin
                bad++; $display("FAIL reset_rd2[%0d] got=%h exp=00000000", i, read_data2);
            end
        end
    endtask

    task automatic test_write_read;
        write_reg(5'd1, 32'h80000001);
        write_reg(5'd2, 32'h80000000);
        rr1 = 5'd1; rr2 = 5'd2; #1;
        total++;
        if (read_data1 !== 32'h80000001) begin
            bad++; $display("FAIL rd_r1 got=%h exp=80000001", read_data1);
        end
        total++;
        if (read_data2 !== 32'h80000000) begin
            bad++; $display("FAIL rd_r2 got=%h exp=80000000", read_data2);
        end
    endtask

    task automatic test_no_bypass;
        @(negedge clk);
        gpr_wr = 1'b1; wr = 5'd5; wd = 32'hA5A5A5A5; slt_wr = 1'b0; rr1 = 5'd5; alu_sel = 2'b10;
        #1;
        total++;
        if (read_data1 !== 32'h0) begin
            bad++; $display("FAIL no_bypass_pre got=%h exp=00000000", read_data1);
        end
        @(posedge clk); #1;
        gpr_wr = 1'b0;
        total++;
        if (read_data1 !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL no_bypass_post got=%h exp=a5a5a5a5", read_data1);
        end
    endtask

    task automatic test_add_overflow;
        rr1 = 5'd1; alu_b = 32'h80000000; alu_sel = 2'b00; #1;
        total++;
        if ({alu_out, overflow, zero, less_than} !== {32'h00000001, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL add_ovf got=%h/o%b/z%b/l%b exp=00000001/o1/z0/l0", alu_out, overflow, zero, less_than);
        end
    endtask

    task automatic test_alu_patterns;
        logic [31:0] exp_out [0:4];
        logic [1:0]  sel [0:4];
        logic [4:0]  a_adr [0:4];
        logic [31:0] bv [0:4];
        logic        exp_ov [0:4];
        logic        exp_z [0:4];
        logic        exp_lt [0:4];
        // A = r1 (0x80000001), r2 (0x80000000) or r0
        a_adr = '{5'd2, 5'd1, 5'd1, 5'd1, 5'd0};
        bv    = '{32'h00000001, 32'h0000F0F0, 32'h80000000, 32'h80000001, 32'h00000000};
        sel   = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b00};
        exp_out = '{32'h7FFFFFFF, 32'h8000F0F1, 32'h80000000, 32'h00000000, 32'h00000000};
        exp_ov  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_z   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_lt  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rr1 = a_adr[i]; alu_b = bv[i]; alu_sel = sel[i]; #1;
            total++;
            if ({alu_out, overflow, zero, less_than} !== {exp_out[i], exp_ov[i], exp_z[i], exp_lt[i]}) begin
                bad++;
                $display("FAIL alu_vec%0d got=%h/o%b/z%b/l%b exp=%h/o%b/z%b/l%b", i, alu_out, overflow,
                         zero, less_than, exp_out[i], exp_ov[i], exp_z[i], exp_lt[i]);
            end
        end
    endtask

    task automatic test_ovf_flag;
        logic [31:0] v;
        @(negedge clk);
        rr1 = 5'd1; alu_b = 32'h80000000; alu_sel = 2'b00;
        gpr_wr = 1'b1; wr = 5'd3; wd = 32'h00000001; slt_wr = 1'b0;
        @(posedge clk); #1;
        gpr_wr = 1'b0;
        read_reg(5'd3, v);
        total++;
        if (v !== 32'h00000001) begin
            bad++; $display("FAIL ovf_r3 got=%h exp=00000001", v);
        end
        read_reg(5'd30, v);
        total++;
        if (v !== (FLAG_EN ? 32'h00000001 : 32'h00000000)) begin
            bad++; $display("FAIL ovf_r30 got=%h exp=%h", v, FLAG_EN ? 32'h1 : 32'h0);
        end
        // overflowing write straight into r30
        @(negedge clk);
        rr1 = 5'd1; alu_b = 32'h80000000; alu_sel = 2'b00;
        gpr_wr = 1'b1; wr = 5'd30; wd = 32'hFFFFFFF0; slt_wr = 1'b0;
        @(posedge clk); #1;
        gpr_wr = 1'b0;
        read_reg(5'd30, v);
        total++;
        if (v !== (FLAG_EN ? 32'hFFFFFFF1 : 32'hFFFFFFF0)) begin
            bad++; $display("FAIL ovf_r30_wr got=%h exp=%h", v, FLAG_EN ? 32'hFFFFFFF1 : 32'hFFFFFFF0);
        end
    endtask

    task automatic test_r0;
        logic [31:0] v;
        write_reg(5'd0, 32'hFFFFFFFF);
        rr2 = 5'd0;
        read_reg(5'd0, v);
        total++;
        if (v !== 32'h0 || read_data2 !== 32'h0) begin
            bad++; $display("FAIL r0_write got=%h/%h exp=00000000", v, read_data2);
        end
    endtask

    task automatic test_slt;
        logic [31:0] v;
        @(negedge clk);
        rr1 = 5'd2; alu_b = 32'h00000001; alu_sel = 2'b10;
        gpr_wr = 1'b1; slt_wr = 1'b1; wr = 5'd4; wd = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(negedge clk);
        rr1 = 5'd1; alu_b = 32'h80000000; wr = 5'd5; wd = 32'hFFFFFFFF;
        @(posedge clk); #1;
        gpr_wr = 1'b0; slt_wr = 1'b0;
        read_reg(5'd4, v);
        total++;
        if (v !== 32'h00000001) begin
            bad++; $display("FAIL slt_r4 got=%h exp=00000001", v);
        end
        read_reg(5'd5, v);
        total++;
        if (v !== 32'h00000000) begin
            bad++; $display("FAIL slt_r5 got=%h exp=00000000", v);
        end
    endtask

    task automatic test_rst_mid_write;
        logic [31:0] v;
        @(negedge clk);
        gpr_wr = 1'b1; wr = 5'd6; wd = 32'h12345678; slt_wr = 1'b0;
        rr1 = 5'd1; alu_b = 32'h00000005; alu_sel = 2'b00;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (read_data1 !== 32'h0) begin
            bad++; $display("FAIL rst_rd1 got=%h exp=00000000", read_data1);
        end
        total++;
        if (alu_out !== 32'h00000005 || overflow !== 1'b0) begin
            bad++; $display("FAIL rst_alu got=%h/o%b exp=00000005/o0", alu_out, overflow);
        end
        @(negedge clk);
        gpr_wr = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_reg(i[4:0], v);
            total++;
            if (v !== 32'h0) begin
                bad++; $display("FAIL rst_mid[%0d] got=%h exp=00000000", i, v);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_write_read();
        test_no_bypass();
        test_add_overflow();
        test_alu_patterns();
        test_ovf_flag();
        test_r0();
        test_slt();
        test_rst_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpr_alu.md
GPR_ALU -- requirements
Module: gpr_alu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-002 Port list (name  direction  width  meaning) SHALL be exactly as follows:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- gpr_wr  input  1  register write enable
- rr1  input  5  read address, port 1 (ALU operand A)
- rr2  input  5  read address, port 2
- wr  input  5  write address
- wd  input  32  write data
- slt_wr  input  1  write less_than result instead of wd
- alu_b  input  32  ALU operand B
- alu_sel  input  2  ALU operation select
- read_data1  output  32  register[rr1]
- read_data2  output  32  register[rr2]
- alu_out  output  32  ALU result
- zero  output  1  alu_out == 0
- overflow  output  1  signed overflow of ADD/SUB
- less_than  output  1  signed read_data1 < alu_b

Function
REQ-003 The register file SHALL hold 32 registers of 32 bits; register 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-004 read_data1 and read_data2 SHALL be combinational from rr1/rr2, with no write-to-read bypass: a same-cycle write is visible only after the clock edge.
REQ-005 On a rising clk edge with gpr_wr=1 and wr!=0, register[wr] SHALL load wd if slt_wr=0, or {31'b0, less_than} if slt_wr=1.
REQ-006 ALU operand A SHALL be read_data1, and operand B SHALL be alu_b.
REQ-007 alu_sel operations SHALL be: 00 = A+B; 01 = A-B; 10 = A|B; 11 = A&B. Results SHALL be 32-bit and wrap modulo 2^32.
REQ-008 overflow SHALL be the two's-complement signed overflow for alu_sel 00 and 01, and SHALL be 0 for alu_sel 10 and 11.
REQ-009 zero SHALL be 1 when alu_out is 0x00000000; less_than SHALL be the signed A<B comparison, independent of alu_sel.
REQ-010 The ALU SHALL be purely combinational, with zero cycles of latency.

Reset
REQ-011 When rst=1, all 32 registers SHALL clear to 0x00000000 immediately, regardless of clk.
REQ-012 While rst is held high, writes SHALL be blocked; read_data1 and read_data2 SHALL read 0.
REQ-013 ALU outputs during reset SHALL follow from A=0 and the current alu_b.

Configuration
REQ-014 With macro GPR_ALU_OVF_FLAG_EN defined: on a write edge (gpr_wr=1) where overflow=1, bit 0 of register 30 SHALL be set to 1, and the normal wr write SHALL still occur.
REQ-015 With GPR_ALU_OVF_FLAG_EN defined and wr=30 on the same edge, bit 0 of register 30 SHALL be 1 (flag wins) and bits 31:1 SHALL take the written data.
REQ-016 Without GPR_ALU_OVF_FLAG_EN, register 30 SHALL be an ordinary register, and overflow SHALL remain an output only.

Verification
REQ-017 Scenario: rst pulse, then read all addresses -> every read returns 0x00000000.
REQ-018 Scenario: write r1=0x80000001 and r2=0x80000000; read rr1=1, rr2=2 -> 0x80000001 and 0x80000000.
REQ-019 Scenario: rr1=1 (0x80000001), alu_b=0x80000000, alu_sel=00 -> alu_out=0x00000001, overflow=1, zero=0, less_than=0.
REQ-020 Scenario: GPR_ALU_OVF_FLAG_EN defined; perform the REQ-019 add with gpr_wr=1, wr=3 -> r3=0x00000001 and r30=0x00000001. With the macro undefined -> r30 stays 0.
REQ-021 Scenario: write wr=0, wd=0xFFFFFFFF -> rr1=0 reads 0.
- Also: rr1=2 (0x80000000), alu_b=1, alu_sel=01 -> alu_out=0x7FFFFFFF, overflow=1.
REQ-022 Scenario: slt_wr=1, gpr_wr=1, wr=4, A=0x80000000, B=1 -> r4=0x00000001.
- Also: assert rst mid-write -> no write occurs and all registers are 0.
